pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage MIPS core. Merges per-stage stall requests into the 6-bit `stall` vector consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Sequences exception and `eret` redirection from the MEM stage through a small FSM:

- freezes the pipe for one cycle;
- then asserts a one-cycle `flush` with the redirect PC.

Also keeps stall statistics and a consecutive-stall watchdog.

---
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the five-stage core: merges stage stall requests and
// sequences exception/eret redirection through a freeze-then-flush FSM.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WD_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [6:0]  i_except,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  localparam int unsigned CW = $clog2(WD_LIMIT) + 1;

  typedef enum logic [1:0] {RUN, WAIT_MEM, FREEZE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [5:0]      merged;
  logic [5:0]      stall_int;
  logic            exc_req;
  logic            stall_any;
  logic [31:0]     new_pc_r;
  logic [CW-1:0]   consec;

  assign exc_req = (i_except != 7'd0) | i_eret;

  always_comb begin
    merged = 6'b000000;
    if (stallreq_mem)     merged = 6'b011111;
    else if (stallreq_ex) merged = 6'b001111;
    else if (stallreq_id) merged = 6'b000111;
    else if (stallreq_if) merged = 6'b000011;
  end

  always_comb begin
    state_nxt = state;
    stall_int = '0;
    flush     = 1'b0;
    new_pc    = '0;
    case (state)
      RUN: begin
        stall_int = merged;
        if (exc_req) state_nxt = stallreq_mem ? WAIT_MEM : FREEZE;
      end
      WAIT_MEM: begin
        stall_int = merged;
        if (!stallreq_mem) state_nxt = FREEZE;
      end
      FREEZE: begin
        stall_int = '1;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        flush     = 1'b1;
        new_pc    = new_pc_r;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Merge is combinational, so gate it to keep the pipe quiet while reset is held.
  assign stall     = reset ? stall_int : '0;
  assign stall_any = |stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      new_pc_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == FREEZE) new_pc_r <= i_eret ? i_epc : EXC_VECTOR;
    end
  end

  // Timeout is set from the incoming count so it rises right after the limit-th stalled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stall_any && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (!stall_any)                       consec <= '0;
      else if (consec != CW'(WD_LIMIT))     consec <= consec + CW'(1);
      if (stall_any && consec == CW'(WD_LIMIT - 1)) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (watchdog limit reduced to 8).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [6:0]  i_except;
  logic        i_eret;
  logic [31:0] i_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .WD_LIMIT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .i_except      (i_except),
    .i_eret        (i_eret),
    .i_epc         (i_epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_reqs(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    stallreq_if  = r_if;
    stallreq_id  = r_id;
    stallreq_ex  = r_ex;
    stallreq_mem = r_mem;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    set_reqs(1, 1, 1, 1);
    i_except = 7'h00;
    i_eret   = 1'b0;
    i_epc    = 32'h0;

    tick(); tick(); #1;
    chk("rst_stall",   32'(stall), 32'h0);
    chk("rst_flush",   32'(flush), 32'h0);
    chk("rst_new_pc",  new_pc, 32'h0);
    chk("rst_cycles",  stall_cycles, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);

    reset = 1'b1;
    set_reqs(0, 0, 0, 0);
    #1 chk("rel_stall", 32'(stall), 32'h0);

    tick(); stallreq_id = 1'b1;
    #1 chk("id_stall", 32'(stall), 32'h07);
    tick(); stallreq_id = 1'b0;
    #1 chk("id_cycles", stall_cycles, 32'd1);
    chk("gap_stall", 32'(stall), 32'h0);

    tick(); set_reqs(1, 1, 1, 0);
    #1 chk("prio_ex", 32'(stall), 32'h0F);
    tick(); stallreq_mem = 1'b1;
    #1 chk("prio_mem", 32'(stall), 32'h1F);
    repeat (4) begin
      tick(); #1 chk("prio_mem_hold", 32'(stall), 32'h1F);
    end
    tick(); set_reqs(0, 0, 0, 0);
    #1 chk("prio_cycles", stall_cycles, 32'd7);
    chk("prio_gap", 32'(stall), 32'h0);

    // Exception with no memory stall: detect, freeze, flush.
    tick(); i_except = 7'h04;
    #1 chk("exc_detect_stall", 32'(stall), 32'h0);
    chk("exc_detect_flush", 32'(flush), 32'h0);
    tick(); #1;
    chk("exc_freeze_stall", 32'(stall), 32'h3F);
    chk("exc_freeze_flush", 32'(flush), 32'h0);
    chk("exc_freeze_new_pc", new_pc, 32'h0);
    tick(); set_reqs(1, 0, 0, 1);
    #1 chk("exc_flush", 32'(flush), 32'h1);
    chk("exc_flush_new_pc", new_pc, 32'hBFC00380);
    chk("exc_flush_stall", 32'(stall), 32'h0);
    chk("exc_cycles", stall_cycles, 32'd8);
    tick(); i_except = 7'h00; set_reqs(0, 0, 0, 0);
    #1 chk("exc_after_flush", 32'(flush), 32'h0);
    chk("exc_after_new_pc", new_pc, 32'h0);
    chk("exc_after_stall", 32'(stall), 32'h0);

    // Eret (with a concurrent exception cause) behind a memory stall.
    tick();
    i_eret = 1'b1; i_except = 7'h01; i_epc = 32'h8000_1234; stallreq_mem = 1'b1;
    #1 chk("eret_detect_stall", 32'(stall), 32'h1F);
    repeat (3) begin
      tick(); #1;
      chk("eret_wait_stall", 32'(stall), 32'h1F);
      chk("eret_wait_flush", 32'(flush), 32'h0);
    end
    tick(); stallreq_mem = 1'b0;
    #1 chk("eret_wait_release_stall", 32'(stall), 32'h0);
    chk("eret_wait_release_flush", 32'(flush), 32'h0);
    tick(); #1 chk("eret_freeze_stall", 32'(stall), 32'h3F);
    tick(); #1;
    chk("eret_flush", 32'(flush), 32'h1);
    chk("eret_new_pc", new_pc, 32'h8000_1234);
    chk("eret_cycles", stall_cycles, 32'd13);
    tick(); i_eret = 1'b0; i_except = 7'h00; i_epc = 32'h0;
    #1 chk("eret_after_flush", 32'(flush), 32'h0);
    chk("eret_after_new_pc", new_pc, 32'h0);

    // Watchdog: two runs of 7 separated by a gap must not trip it.
    stallreq_ex = 1'b1;
    repeat (7) tick();
    stallreq_ex = 1'b0;
    #1 chk("wd_run7_a", 32'(stall_timeout), 32'h0);
    tick(); stallreq_ex = 1'b1;
    repeat (7) tick();
    stallreq_ex = 1'b0;
    #1 chk("wd_run7_b", 32'(stall_timeout), 32'h0);
    tick(); stallreq_ex = 1'b1;
    repeat (7) tick();
    #1 chk("wd_pre_trip", 32'(stall_timeout), 32'h0);
    tick(); stallreq_ex = 1'b0;
    #1 chk("wd_trip", 32'(stall_timeout), 32'h1);
    repeat (3) tick();
    #1 chk("wd_sticky", 32'(stall_timeout), 32'h1);
    chk("wd_cycles", stall_cycles, 32'd35);

    // Reset asserted during FREEZE aborts the redirect.
    i_except = 7'h02;
    tick(); #1 chk("rf_freeze_stall", 32'(stall), 32'h3F);
    reset = 1'b0; i_except = 7'h00;
    #1 chk("rf_abort_stall", 32'(stall), 32'h0);
    chk("rf_abort_flush", 32'(flush), 32'h0);
    chk("rf_abort_timeout", 32'(stall_timeout), 32'h0);
    chk("rf_abort_cycles", stall_cycles, 32'h0);
    tick(); #1 chk("rf_inreset_flush", 32'(flush), 32'h0);
    reset = 1'b1;
    tick(); #1;
    chk("rf_post_flush", 32'(flush), 32'h0);
    chk("rf_post_new_pc", new_pc, 32'h0);
    tick(); stallreq_id = 1'b1;
    #1 chk("rf_post_run_stall", 32'(stall), 32'h07);
    chk("rf_post_flush2", 32'(flush), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
